tex_footprint_gen: RTL

- Sits directly downstream of the texture coordinate wrap/clamp stage in the texture unit.
- Takes resolved integer texel coordinates for a sample (the top-left texel and its +1 neighbour, each already wrapped) plus the border flag.
- Expands the sample into a sequence of texel memory read requests: 4 for bilinear, 1 for nearest, none for border.
- Drives those requests one per cycle to the texel cache under a valid/ready handshake.

---
 rtl/tex_pkg.sv | 55 +++++
 rtl/tex_texel_addr_calc.sv | 33 +++
 rtl/tex_footprint_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tex_pkg.sv
// Shared texture-unit definitions: footprint quad indices, FSM state encoding,
// and small helpers for the footprint generator and address stages.
package tex_pkg;

   localparam logic [1:0] Q00 = 2'd0;
   localparam logic [1:0] Q10 = 2'd1;
   localparam logic [1:0] Q01 = 2'd2;
   localparam logic [1:0] Q11 = 2'd3;

   localparam logic [2:0] BPP_LOG2_MAX = 3'd4;

   typedef logic [0:0] state_t;
   localparam state_t S_IDLE  = 1'b0;
   localparam state_t S_ISSUE = 1'b1;

   function automatic logic [2:0] clamp_bpp(input logic [2:0] bpp);
      return (bpp > BPP_LOG2_MAX) ? BPP_LOG2_MAX : bpp;
   endfunction

   // Quad 0 is always enabled, so every accepted sample yields at least one beat.
   function automatic logic [3:0] quad_mask(input logic border,
                                            input logic bilinear,
                                            input logic dedup,
                                            input logic x_eq,
                                            input logic y_eq);
      logic [3:0] m;
      m = 4'b0001;
      if (!border && bilinear) begin
         m = 4'b1111;
         if (dedup && x_eq) begin
            m[Q10] = 1'b0;
            m[Q11] = 1'b0;
         end
         if (dedup && y_eq) begin
            m[Q01] = 1'b0;
            m[Q11] = 1'b0;
         end
      end
      return m;
   endfunction

   // Returns {found, index} of the lowest enabled quad strictly above cur.
   function automatic logic [2:0] next_enabled(input logic [3:0] mask,
                                               input logic [1:0] cur);
      logic [2:0] r;
      r = '0;
      for (int unsigned q = 0; q < 4; q++) begin
         if (!r[2] && mask[q] && (q > 32'(cur))) begin
            r = {1'b1, q[1:0]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tex_texel_addr_calc.sv
// Texel address arithmetic: full-width row products for two rows, and the
// per-beat byte address base + row_prod + (x << bpp), modulo 2^AW.
module tex_texel_addr_calc #(
   parameter int W  = 12,
   parameter int AW = 32,
   parameter int PW = 16
) (
   input  logic [W-1:0]    row_y0,
   input  logic [W-1:0]    row_y1,
   input  logic [PW-1:0]   pitch,
   output logic [W+PW-1:0] row_prod0,
   output logic [W+PW-1:0] row_prod1,
   input  logic [AW-1:0]   base,
   input  logic [W+PW-1:0] row_prod,
   input  logic [W-1:0]    col_x,
   input  logic [2:0]      bpp_log2,
   output logic [AW-1:0]   addr
);
   import tex_pkg::*;

   logic [W+PW-1:0] pitch_ext;
   logic [AW-1:0]   col_off;
   logic [AW-1:0]   row_off;

   assign pitch_ext = {{W{1'b0}}, pitch};
   assign row_prod0 = {{PW{1'b0}}, row_y0} * pitch_ext;
   assign row_prod1 = {{PW{1'b0}}, row_y1} * pitch_ext;

   assign col_off = AW'(col_x) << clamp_bpp(bpp_log2);
   assign row_off = AW'(row_prod);
   assign addr    = base + row_off + col_off;

endmodule

// File: rtl/tex_footprint_gen.sv
// Expands a wrapped texture sample into 1..4 texel read requests (or a single
// border token) issued one per cycle under a valid/ready handshake.
module tex_footprint_gen #(
   parameter int W     = 12,
   parameter int AW    = 32,
   parameter int PW    = 16,
   parameter int TAGW  = 8,
   parameter int DEDUP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_x0,
   input  logic [W-1:0]    in_y0,
   input  logic [W-1:0]    in_x1,
   input  logic [W-1:0]    in_y1,
   input  logic            in_border,
   input  logic            in_bilinear,
   input  logic [TAGW-1:0] in_tag,
   input  logic [AW-1:0]   base_addr,
   input  logic [PW-1:0]   row_pitch,
   input  logic [2:0]      bpp_log2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [AW-1:0]   out_addr,
   output logic [1:0]      out_quad,
   output logic            out_last,
   output logic            out_border,
   output logic [TAGW-1:0] out_tag
);
   import tex_pkg::*;

   state_t            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        quad_q, quad_d;
   logic [3:0]        mask_q, mask_d;
   logic [W-1:0]      x0_q, x0_d;
   logic [W-1:0]      x1_q, x1_d;
   logic [W+PW-1:0]   prod0_q, prod0_d;
   logic [W+PW-1:0]   prod1_q, prod1_d;
   logic [AW-1:0]     base_q, base_d;
   logic [2:0]        bpp_q, bpp_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic              border_q, border_d;

   logic [W+PW-1:0]   row_prod0, row_prod1;
   logic [W+PW-1:0]   sel_prod;
   logic [W-1:0]      sel_x;
   logic [AW-1:0]     calc_addr;
   logic [2:0]        nxt;
   logic              is_last;
   logic              fire;
   logic              accept;

   // Multipliers see only the input-side y values; the beat path is a mux and an add.
   tex_texel_addr_calc #(
      .W  (W),
      .AW (AW),
      .PW (PW)
   ) u_addr_calc (
      .row_y0    (in_y0),
      .row_y1    (in_y1),
      .pitch     (row_pitch),
      .row_prod0 (row_prod0),
      .row_prod1 (row_prod1),
      .base      (base_q),
      .row_prod  (sel_prod),
      .col_x     (sel_x),
      .bpp_log2  (bpp_q),
      .addr      (calc_addr)
   );

   assign sel_prod = quad_q[1] ? prod1_q : prod0_q;
   assign sel_x    = quad_q[0] ? x1_q : x0_q;

   assign nxt      = next_enabled(mask_q, quad_q);
   assign is_last  = ~nxt[2];
   assign fire     = out_valid_q & out_ready;
   assign in_ready = (state_q == S_IDLE) | (fire & is_last);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      quad_d      = quad_q;
      mask_d      = mask_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      prod0_d     = prod0_q;
      prod1_d     = prod1_q;
      base_d      = base_q;
      bpp_d       = bpp_q;
      tag_d       = tag_q;
      border_d    = border_q;

      if (accept) begin
         state_d     = S_ISSUE;
         out_valid_d = 1'b1;
         quad_d      = Q00;
         mask_d      = quad_mask(in_border, in_bilinear, DEDUP != 0,
                                 in_x1 == in_x0, in_y1 == in_y0);
         x0_d        = in_x0;
         x1_d        = in_x1;
         prod0_d     = row_prod0;
         prod1_d     = row_prod1;
         base_d      = base_addr;
         bpp_d       = clamp_bpp(bpp_log2);
         tag_d       = in_tag;
         border_d    = in_border;
      end else if (fire) begin
         if (is_last) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end else begin
            quad_d = nxt[1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         quad_q      <= '0;
         mask_q      <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         prod0_q     <= '0;
         prod1_q     <= '0;
         base_q      <= '0;
         bpp_q       <= '0;
         tag_q       <= '0;
         border_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         quad_q      <= quad_d;
         mask_q      <= mask_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         prod0_q     <= prod0_d;
         prod1_q     <= prod1_d;
         base_q      <= base_d;
         bpp_q       <= bpp_d;
         tag_q       <= tag_d;
         border_q    <= border_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_quad   = quad_q;
   assign out_tag    = tag_q;
   assign out_last   = out_valid_q & is_last;
   assign out_border = out_valid_q & border_q;
   assign out_addr   = border_q ? '0 : calc_addr;

endmodule
